program_record_streamer: RTL and testbench

Parametrised record decoder for the UPDI programmer's program ROM. It walks the stripped Intel-hex-style record image held in a synchronous 8-bit ROM and emits each record's header. Data bytes are streamed one at a time over a valid/ready handshake rather than buffered in an array. It verifies a per-record checksum, flags malformed records, and detects the end-of-program record, then hands blocks to the UPDI write sequencer.

---
 rtl/program_record_streamer.sv | 244 ++++++++++++++++++++++++
 tb/tb_program_record_streamer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_record_streamer.sv
// program_record_streamer: walks a stripped hex record image in a synchronous
// ROM, publishes each record header, streams data bytes over valid/ready and
// verifies the per-record checksum.
module program_record_streamer #(
  parameter int unsigned PROGRAM_SIZE   = 1024,
  parameter int unsigned PROG_ADDR_BITS = $clog2(PROGRAM_SIZE),
  parameter int unsigned ADDR_BYTES     = 2,
  parameter int unsigned MAX_BLOCK_LEN  = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic [PROG_ADDR_BITS-1:0] prog_addr,
  input  logic [7:0]                prog_data,
  input  logic                      start,
  input  logic                      rewind,
  output logic                      ready,
  output logic                      block_valid,
  output logic [7:0]                block_length,
  output logic [8*ADDR_BYTES-1:0]   block_address,
  output logic [7:0]                block_type,
  output logic [7:0]                data_out,
  output logic                      data_valid,
  input  logic                      data_ready,
  output logic                      data_last,
  output logic                      block_done,
  output logic                      eof,
  output logic                      err,
  output logic [1:0]                err_code
);

  localparam int unsigned AW = 8 * ADDR_BYTES;
  localparam logic [PROG_ADDR_BITS-1:0] LAST_ADDR = PROG_ADDR_BITS'(PROGRAM_SIZE - 1);
  localparam logic [7:0] MAX_LEN  = 8'(MAX_BLOCK_LEN);
  localparam logic [2:0] TYPE_IDX = 3'(ADDR_BYTES + 1);
  localparam logic [1:0] CODE_LEN  = 2'd1;
  localparam logic [1:0] CODE_CSUM = 2'd2;
  localparam logic [1:0] CODE_OVR  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_HDR,
    S_FETCH_DATA,
    S_HOLD_DATA,
    S_FETCH_CSUM
  } state_t;

  state_t                    state_q, state_d;
  logic                      phase_q, phase_d;   // 0: address settle, 1: capture
  logic [2:0]                idx_q, idx_d;
  logic [7:0]                beat_q, beat_d;
  logic [7:0]                sum_q, sum_d;

  logic [PROG_ADDR_BITS-1:0] prog_addr_d;
  logic                      ready_d;
  logic                      block_valid_d;
  logic [7:0]                block_length_d;
  logic [AW-1:0]             block_address_d;
  logic [7:0]                block_type_d;
  logic [7:0]                data_out_d;
  logic                      data_valid_d;
  logic                      data_last_d;
  logic                      block_done_d;
  logic                      eof_d;
  logic                      err_d;
  logic [1:0]                err_code_d;

  logic                      at_last;
  logic [PROG_ADDR_BITS-1:0] addr_inc;
  logic [7:0]                sum_nxt;
  logic                      accept;

  assign at_last  = (prog_addr == LAST_ADDR);
  assign addr_inc = at_last ? prog_addr : prog_addr + PROG_ADDR_BITS'(1);
  assign sum_nxt  = sum_q + prog_data;
  assign accept   = ready && start && !eof && !rewind;

  // Next-state and next-output logic for the record walker.
  always_comb begin
    state_d         = state_q;
    phase_d         = phase_q;
    idx_d           = idx_q;
    beat_d          = beat_q;
    sum_d           = sum_q;
    prog_addr_d     = prog_addr;
    block_valid_d   = block_valid;
    block_length_d  = block_length;
    block_address_d = block_address;
    block_type_d    = block_type;
    data_out_d      = data_out;
    data_valid_d    = data_valid;
    data_last_d     = data_last;
    block_done_d    = 1'b0;
    eof_d           = eof;
    err_d           = err;
    err_code_d      = err_code;

    case (state_q)
      S_IDLE: begin
        if (rewind) begin
          prog_addr_d = '0;
          eof_d       = 1'b0;
        end else if (accept) begin
          state_d    = S_FETCH_HDR;
          phase_d    = 1'b0;
          idx_d      = '0;
          sum_d      = '0;
          err_d      = 1'b0;
          err_code_d = '0;
        end
      end

      S_FETCH_HDR: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d     = 1'b0;
          prog_addr_d = addr_inc;
          sum_d       = sum_nxt;
          idx_d       = idx_q + 3'd1;
          if (idx_q == 3'd0) begin
            block_length_d = prog_data;
          end else if (idx_q < TYPE_IDX) begin
            block_address_d = {block_address[AW-9:0], prog_data};
          end else begin
            block_type_d  = prog_data;
            block_valid_d = 1'b1;
          end
          if (idx_q == 3'd0 && prog_data > MAX_LEN) begin
            err_d        = 1'b1;
            err_code_d   = CODE_LEN;
            block_done_d = 1'b1;
            state_d      = S_IDLE;
          end else if (at_last) begin
            err_d         = 1'b1;
            err_code_d    = CODE_OVR;
            block_done_d  = 1'b1;
            block_valid_d = 1'b0;
            state_d       = S_IDLE;
          end else if (idx_q == TYPE_IDX) begin
            beat_d  = '0;
            state_d = (block_length != 8'd0) ? S_FETCH_DATA : S_FETCH_CSUM;
          end
        end
      end

      S_FETCH_DATA: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d     = 1'b0;
          prog_addr_d = addr_inc;
          sum_d       = sum_nxt;
          if (at_last) begin
            err_d         = 1'b1;
            err_code_d    = CODE_OVR;
            block_done_d  = 1'b1;
            block_valid_d = 1'b0;
            state_d       = S_IDLE;
          end else begin
            data_out_d   = prog_data;
            data_valid_d = 1'b1;
            data_last_d  = (beat_q == block_length - 8'd1);
            beat_d       = beat_q + 8'd1;
            state_d      = S_HOLD_DATA;
          end
        end
      end

      S_HOLD_DATA: begin
        if (data_ready) begin
          data_valid_d = 1'b0;
          data_last_d  = 1'b0;
          state_d      = data_last ? S_FETCH_CSUM : S_FETCH_DATA;
        end
      end

      S_FETCH_CSUM: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d       = 1'b0;
          prog_addr_d   = addr_inc;
          block_done_d  = 1'b1;
          block_valid_d = 1'b0;
          state_d       = S_IDLE;
          if (sum_nxt != 8'd0) begin
            err_d      = 1'b1;
            err_code_d = CODE_CSUM;
          end else if (block_type == 8'h01) begin
            eof_d = 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      phase_q       <= 1'b0;
      idx_q         <= '0;
      beat_q        <= '0;
      sum_q         <= '0;
      prog_addr     <= '0;
      ready         <= 1'b0;
      block_valid   <= 1'b0;
      block_length  <= '0;
      block_address <= '0;
      block_type    <= '0;
      data_out      <= '0;
      data_valid    <= 1'b0;
      data_last     <= 1'b0;
      block_done    <= 1'b0;
      eof           <= 1'b0;
      err           <= 1'b0;
      err_code      <= '0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      idx_q         <= idx_d;
      beat_q        <= beat_d;
      sum_q         <= sum_d;
      prog_addr     <= prog_addr_d;
      ready         <= ready_d;
      block_valid   <= block_valid_d;
      block_length  <= block_length_d;
      block_address <= block_address_d;
      block_type    <= block_type_d;
      data_out      <= data_out_d;
      data_valid    <= data_valid_d;
      data_last     <= data_last_d;
      block_done    <= block_done_d;
      eof           <= eof_d;
      err           <= err_d;
      err_code      <= err_code_d;
    end
  end

endmodule

// File: tb/tb_program_record_streamer.sv
// Self-checking bench for program_record_streamer with a record-level
// reference model and a behavioural registered ROM.
module tb_program_record_streamer;

  localparam int unsigned PSIZE = 64;
  localparam int unsigned AB    = 2;
  localparam int unsigned MAXL  = 64;
  localparam int unsigned HDR   = AB + 2;
  localparam int unsigned LAST  = PSIZE - 1;

  logic        clk = 1'b0;
  logic        rst, start, rewind, data_ready;
  logic [5:0]  prog_addr;
  logic [7:0]  prog_data;
  logic        ready, block_valid, data_valid, data_last, block_done, eof, err;
  logic [7:0]  block_length, block_type, data_out;
  logic [15:0] block_address;
  logic [1:0]  err_code;

  logic [7:0]  rom [PSIZE];

  int errors = 0;
  int checks = 0;
  int unsigned pc_model;

  logic [7:0]  exp_len, exp_type;
  logic [15:0] exp_addr;
  logic [7:0]  exp_data [$];
  int unsigned exp_code, exp_pc;
  bit          exp_eof, exp_hdr;

  program_record_streamer #(
    .PROGRAM_SIZE(PSIZE), .ADDR_BYTES(AB), .MAX_BLOCK_LEN(MAXL)
  ) dut (
    .clk(clk), .rst(rst), .prog_addr(prog_addr), .prog_data(prog_data),
    .start(start), .rewind(rewind), .ready(ready), .block_valid(block_valid),
    .block_length(block_length), .block_address(block_address),
    .block_type(block_type), .data_out(data_out), .data_valid(data_valid),
    .data_ready(data_ready), .data_last(data_last), .block_done(block_done),
    .eof(eof), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  always @(posedge clk) prog_data <= rom[prog_addr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Parse one record from pc_model following the record-format rules.
  task automatic model_record();
    int unsigned pc, total, i;
    logic [7:0]  sum, b;
    pc = pc_model; sum = 8'd0; exp_code = 0; exp_hdr = 0; exp_eof = 0;
    exp_len = 8'd0; exp_addr = 16'd0; exp_type = 8'd0;
    exp_data.delete();
    i = 0; total = HDR + 1;
    while (i < total) begin
      b = rom[pc];
      if (i == 0 && b > 8'(MAXL)) begin
        exp_len = b;
        exp_code = 1;
        if (pc != LAST) pc++;
        break;
      end
      if (i == 0) total = HDR + 32'(b) + 1;
      if (pc == LAST && i != total - 1) begin
        exp_code = 3;
        break;
      end
      if (i == 0) exp_len = b;
      else if (i <= AB) exp_addr = {exp_addr[7:0], b};
      else if (i == AB + 1) begin exp_type = b; exp_hdr = 1; end
      else if (i < total - 1) exp_data.push_back(b);
      sum = sum + b;
      if (pc != LAST) pc++;
      i++;
    end
    if (exp_code == 0 && sum != 8'd0) exp_code = 2;
    exp_eof = (exp_code == 0 && exp_type == 8'h01);
    exp_pc  = pc;
  endtask

  // Start one record and follow it to block_done, checking against the model.
  task automatic run_record(input int hold_first, input bit rand_bp);
    int n, beats, accept_n, wait_cnt;
    bit done, hdr_seen, prev_valid, code_seen, dr;
    logic [7:0] held;
    model_record();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("ready_drop", 32'(ready), 32'd0);
    n = 0; beats = 0; accept_n = -100; wait_cnt = 0;
    done = 0; hdr_seen = 0; prev_valid = 0; code_seen = 0; held = 8'd0;
    while (!done && n < 3000) begin
      if (block_valid && !hdr_seen) begin
        hdr_seen = 1;
        chk("hdr_latency", 32'(n), 32'(2 * HDR));
        chk("hdr_len", 32'(block_length), 32'(exp_len));
        chk("hdr_addr", 32'(block_address), 32'(exp_addr));
        chk("hdr_type", 32'(block_type), 32'(exp_type));
      end
      if (exp_code == 1 && err_code == 2'd1 && !code_seen) begin
        code_seen = 1;
        chk("len_err_cycle", 32'(n), 32'd2);
      end
      if (data_valid) begin
        if (!prev_valid)
          chk("beat_timing", 32'(n), 32'((beats == 0) ? 2 * HDR + 2 : accept_n + 2));
        else
          chk("beat_stable", 32'(data_out), 32'(held));
        held = data_out;
        if (beats == 0 && wait_cnt < hold_first) begin
          dr = 1'b0;
          wait_cnt++;
        end else begin
          dr = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        data_ready = dr;
        if (dr) begin
          if (beats < exp_data.size())
            chk("beat_data", 32'(data_out), 32'(exp_data[beats]));
          else
            chk("beat_extra", 32'(beats), 32'(exp_data.size()));
          chk("beat_last", 32'(data_last), 32'(beats == 32'(exp_len) - 1));
          accept_n = n + 1;
          beats++;
        end
        prev_valid = !dr;
      end else begin
        data_ready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b0;
        prev_valid = 0;
      end
      if (block_done) begin
        done = 1;
        chk("done_err", 32'(err), 32'(exp_code != 0));
        chk("done_code", 32'(err_code), exp_code);
        chk("done_addr", 32'(prog_addr), exp_pc);
        chk("done_eof", 32'(eof), 32'(exp_eof));
        chk("done_bvalid", 32'(block_valid), 32'd0);
        chk("beat_count", 32'(beats), 32'(exp_data.size()));
        chk("hdr_seen", 32'(hdr_seen), 32'(exp_hdr));
        if (exp_code == 0 || exp_code == 2)
          chk("csum_timing", 32'(n), 32'((exp_len > 0) ? accept_n + 2 : 2 * HDR + 2));
        pc_model = exp_pc;
      end else begin
        step();
        n++;
      end
    end
    data_ready = 1'b0;
    if (!done) begin
      chk("done_timeout", 32'(done), 32'd1);
    end else begin
      step();
      chk("ready_after_done", 32'(ready), 32'd1);
      chk("done_pulse", 32'(block_done), 32'd0);
    end
  endtask

  task automatic rewind_pulse();
    rewind = 1'b1;
    step();
    rewind = 1'b0;
    pc_model = 0;
    chk("rewind_addr", 32'(prog_addr), 32'd0);
    chk("rewind_eof", 32'(eof), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_addr"}, 32'(prog_addr), 32'd0);
    chk({tag, "_ready"}, 32'(ready), 32'd0);
    chk({tag, "_bvalid"}, 32'(block_valid), 32'd0);
    chk({tag, "_blen"}, 32'(block_length), 32'd0);
    chk({tag, "_baddr"}, 32'(block_address), 32'd0);
    chk({tag, "_btype"}, 32'(block_type), 32'd0);
    chk({tag, "_dout"}, 32'(data_out), 32'd0);
    chk({tag, "_dvalid"}, 32'(data_valid), 32'd0);
    chk({tag, "_dlast"}, 32'(data_last), 32'd0);
    chk({tag, "_done"}, 32'(block_done), 32'd0);
    chk({tag, "_eof"}, 32'(eof), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_code"}, 32'(err_code), 32'd0);
  endtask

  task automatic load_rec_a();
    logic [7:0] rec [7];
    rec = '{8'h02, 8'h01, 8'h00, 8'h00, 8'hAA, 8'h55, 8'hFE};
    for (int i = 0; i < PSIZE; i++) rom[i] = 8'h00;
    for (int i = 0; i < 7; i++) rom[i] = rec[i];
  endtask

  task automatic gen_random_rom();
    int unsigned p, r, len;
    logic [7:0] q [$];
    logic [7:0] sum, typ;
    p = 0;
    while (p < PSIZE) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        rom[p] = 8'd70;
        p++;
        continue;
      end
      len = $urandom_range(0, 6);
      typ = (r < 5) ? 8'h00 : 8'($urandom_range(2, 5));
      q.delete();
      q.push_back(8'(len));
      q.push_back(8'($urandom));
      q.push_back(8'($urandom));
      q.push_back(typ);
      for (int k = 0; k < int'(len); k++) q.push_back(8'($urandom));
      sum = 8'd0;
      foreach (q[k]) sum = sum + q[k];
      q.push_back((r == 9) ? ((8'd0 - sum) ^ 8'h5A) : (8'd0 - sum));
      foreach (q[k]) begin
        if (p < PSIZE) rom[p] = q[k];
        p++;
      end
    end
  endtask

  initial begin
    int dv_wait;
    rst = 1'b1; start = 1'b0; rewind = 1'b0; data_ready = 1'b0;
    pc_model = 0;
    load_rec_a();

    // Reset values, then ready rises after release.
    repeat (3) step();
    check_reset_values("reset");
    rst = 1'b0;
    step();
    chk("ready_after_rst", 32'(ready), 32'd1);

    // Basic record with no backpressure.
    run_record(0, 1'b0);
    chk("rec_a_addr", 32'(prog_addr), 32'd7);

    // Same record with beat 1 held for 5 cycles.
    rewind_pulse();
    run_record(5, 1'b0);

    // Corrupted checksum.
    rom[6] = 8'hFD;
    rewind_pulse();
    run_record(0, 1'b0);
    chk("csum_code", 32'(err_code), 32'd2);

    // Length above the limit.
    rom[0] = 8'h41;
    rewind_pulse();
    run_record(0, 1'b0);
    chk("len_code", 32'(err_code), 32'd1);
    chk("len_addr", 32'(prog_addr), 32'd1);

    // End-of-program record, ignored start, then rewind.
    for (int i = 0; i < PSIZE; i++) rom[i] = 8'h00;
    rom[3] = 8'h01; rom[4] = 8'hFF;
    rewind_pulse();
    run_record(0, 1'b0);
    chk("eof_set", 32'(eof), 32'd1);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("eof_ignore_ready", 32'(ready), 32'd1);
      chk("eof_ignore_bvalid", 32'(block_valid), 32'd0);
      chk("eof_ignore_done", 32'(block_done), 32'd0);
      step();
    end
    chk("eof_ignore_addr", 32'(prog_addr), 32'd5);
    rewind_pulse();

    // Reset during beat 1, then a fresh decode from address 0.
    load_rec_a();
    start = 1'b1;
    step();
    start = 1'b0;
    dv_wait = 0;
    while (!data_valid && dv_wait < 50) begin
      step();
      dv_wait++;
    end
    chk("mid_rst_beat_seen", 32'(data_valid), 32'd1);
    rst = 1'b1;
    step();
    check_reset_values("mid_rst");
    rst = 1'b0;
    pc_model = 0;
    step();
    chk("mid_rst_ready", 32'(ready), 32'd1);
    run_record(0, 1'b0);

    // Random record stream with random backpressure.
    gen_random_rom();
    rewind_pulse();
    for (int k = 0; k < 25; k++) begin
      if (eof) break;
      run_record(0, 1'b1);
      if (exp_code == 3) break;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
